// File: rtl/gray_ptr_rx.sv
// Read-side end of a gray-coded FIFO pointer crossing: synchronizes the writer's
// gray pointer, tracks the binary read pointer and derives empty/count/read handshake.
module gray_ptr_rx #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   wr_ptr_gray_in,
    input  logic              rd_en,
    output logic              rd_fire,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              gray_err
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] sync_out;
    logic [PW-1:0] prev_sample;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_inc;
    logic [PW-1:0] sample_diff;
    logic          multi_bit_step;
    logic          overrun;

    // Handshake: rd_en is a request that may be held at any time; rd_fire is
    // the acceptance, asserted only when an entry is visible, and the read
    // pointer advances on exactly those edges.

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of gray bits i..MSB.
    always_comb begin
        wr_bin = '0;
        for (int i = 0; i < PW; i++) begin
            wr_bin[i] = ^(sync_out >> i);
        end
    end

    assign count      = wr_bin - rd_bin;
    assign empty      = (count == '0);
    assign rd_fire    = rd_en & ~empty;
    assign rd_addr    = rd_bin[ADDR_W-1:0];
    assign rd_bin_inc = rd_bin + 1'b1;

    // More than one bit set in the sample-to-sample difference is an illegal gray step.
    assign sample_diff    = sync_out ^ prev_sample;
    assign multi_bit_step = (sample_diff & (sample_diff - 1'b1)) != '0;
    assign overrun        = count > DEPTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= '0;
            rd_bin      <= '0;
            rd_ptr_gray <= '0;
            gray_err    <= 1'b0;
        end else begin
            prev_sample <= sync_out;
            if (rd_fire) begin
                rd_bin      <= rd_bin_inc;
                rd_ptr_gray <= rd_bin_inc ^ (rd_bin_inc >> 1);
            end
            if (multi_bit_step || overrun) begin
                gray_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Bench for gray_ptr_rx: directed vector table, hand-written corner sequences and
// randomized legal traffic checked against a pointer-level reference model.
module tb_gray_ptr_rx;

    localparam int ADDR_W = 4;
    localparam int SYNC   = 2;
    localparam int PMOD   = 32;

    logic       clk;
    logic       rst;
    logic [4:0] gin;
    logic       rd_en;
    logic       rd_fire;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr_gray;
    logic       empty;
    logic [4:0] count;
    logic       gray_err;

    int n_tests;
    int n_fail;

    // reference model state
    int m_q[$];
    int m_prev;
    int m_rd;
    bit m_err;
    int w_bin;

    gray_ptr_rx #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_ptr_gray_in (gin),
        .rd_en          (rd_en),
        .rd_fire        (rd_fire),
        .rd_addr        (rd_addr),
        .rd_ptr_gray    (rd_ptr_gray),
        .empty          (empty),
        .count          (count),
        .gray_err       (gray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] gin;
        logic       rd_en;
        logic       exp_empty;
        logic [4:0] exp_count;
        logic       exp_fire;
        logic [3:0] exp_addr;
        logic [4:0] exp_gray;
        logic       exp_err;
    } vec_t;

    vec_t vecs[12];

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) % PMOD;
    endfunction

    function automatic int g2b(input int g);
        int b;
        b = 0;
        for (int v = g; v != 0; v = v >> 1) b = b ^ v;
        return b;
    endfunction

    function automatic int m_vis_gray();
        return m_q[0];
    endfunction

    function automatic int m_cnt();
        return (g2b(m_q[0]) - m_rd + PMOD) % PMOD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input int g, input logic re);
        rst   = r;
        gin   = 5'(g);
        rd_en = re;
        #2;
    endtask

    // Advance the model by one edge using the inputs currently applied, then clock the DUT.
    task automatic finish_cycle();
        int q0;
        int c;
        if (rst) begin
            m_q = {};
            for (int i = 0; i < SYNC; i++) m_q.push_back(0);
            m_prev = 0;
            m_rd   = 0;
            m_err  = 1'b0;
        end else begin
            q0 = m_vis_gray();
            c  = m_cnt();
            if ($countones(q0 ^ m_prev) > 1 || c > (1 << ADDR_W)) m_err = 1'b1;
            m_prev = q0;
            if (rd_en && c != 0) m_rd = (m_rd + 1) % PMOD;
            m_q.push_back(int'(gin));
            void'(m_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        int c;
        c = m_cnt();
        chk("m_count",    32'(count),       32'(c));
        chk("m_empty",    32'(empty),       32'(c == 0));
        chk("m_rd_fire",  32'(rd_fire),     32'(rd_en && c != 0));
        chk("m_rd_addr",  32'(rd_addr),     32'(m_rd % 16));
        chk("m_rd_gray",  32'(rd_ptr_gray), 32'(to_gray(m_rd)));
        chk("m_gray_err", 32'(gray_err),    32'(m_err));
    endtask

    task automatic cycle(input logic r, input int g, input logic re, input bit do_chk);
        drive(r, g, re);
        if (do_chk) check_model();
        finish_cycle();
    endtask

    initial begin
        logic [4:0] prev_obs;
        bit         seen_wrap;
        n_tests = 0;
        n_fail  = 0;
        w_bin   = 0;
        rst = 1'b1; gin = '0; rd_en = 1'b0;
        m_q = {};
        for (int i = 0; i < SYNC; i++) m_q.push_back(0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // reset, write visibility and drain
        vecs[0]  = '{1'b1, 5'h00, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0, 5'h00, 1'b0};
        vecs[1]  = '{1'b0, 5'h00, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0, 5'h00, 1'b0};
        vecs[2]  = '{1'b0, 5'h01, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0, 5'h00, 1'b0};
        vecs[3]  = '{1'b0, 5'h03, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0, 5'h00, 1'b0};
        vecs[4]  = '{1'b0, 5'h02, 1'b0, 1'b0, 5'd1, 1'b0, 4'd0, 5'h00, 1'b0};
        vecs[5]  = '{1'b0, 5'h02, 1'b0, 1'b0, 5'd2, 1'b0, 4'd0, 5'h00, 1'b0};
        vecs[6]  = '{1'b0, 5'h02, 1'b1, 1'b0, 5'd3, 1'b1, 4'd0, 5'h00, 1'b0};
        vecs[7]  = '{1'b0, 5'h02, 1'b1, 1'b0, 5'd2, 1'b1, 4'd1, 5'h01, 1'b0};
        vecs[8]  = '{1'b0, 5'h02, 1'b1, 1'b0, 5'd1, 1'b1, 4'd2, 5'h03, 1'b0};
        vecs[9]  = '{1'b0, 5'h02, 1'b1, 1'b1, 5'd0, 1'b0, 4'd3, 5'h02, 1'b0};
        vecs[10] = '{1'b0, 5'h02, 1'b1, 1'b1, 5'd0, 1'b0, 4'd3, 5'h02, 1'b0};
        vecs[11] = '{1'b0, 5'h02, 1'b0, 1'b1, 5'd0, 1'b0, 4'd3, 5'h02, 1'b0};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, int'(vecs[i].gin), vecs[i].rd_en);
            chk($sformatf("vec%0d_empty", i), 32'(empty),       32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_count", i), 32'(count),       32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_fire", i),  32'(rd_fire),     32'(vecs[i].exp_fire));
            chk($sformatf("vec%0d_addr", i),  32'(rd_addr),     32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_gray", i),  32'(rd_ptr_gray), 32'(vecs[i].exp_gray));
            chk($sformatf("vec%0d_err", i),   32'(gray_err),    32'(vecs[i].exp_err));
            finish_cycle();
        end

        // wrap: one legal writer step then one idle cycle, reader always requesting
        w_bin     = 3;
        prev_obs  = rd_ptr_gray;
        seen_wrap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            w_bin = (w_bin + 1) % PMOD;
            for (int k = 0; k < 2; k++) begin
                cycle(0, to_gray(w_bin), 1, 1);
                if (prev_obs == 5'h10 && rd_ptr_gray == 5'h00) seen_wrap = 1'b1;
                prev_obs = rd_ptr_gray;
            end
        end
        chk("wrap_gray_10_to_00", 32'(seen_wrap), 32'd1);
        chk("wrap_no_err", 32'(gray_err), 32'd0);

        // illegal gray jump 0x00 -> 0x03
        cycle(1, 0, 0, 1);
        cycle(0, 3, 0, 1);
        w_bin = 2;
        cycle(0, 3, 0, 1);
        cycle(0, 3, 0, 1);
        #1;
        chk("jump_err_set", 32'(gray_err), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) w_bin = w_bin + 1;
            cycle(0, to_gray(w_bin), 1, 1);
        end
        #1;
        chk("jump_err_sticky", 32'(gray_err), 32'd1);
        cycle(1, 0, 0, 1);
        #1;
        chk("jump_err_cleared", 32'(gray_err), 32'd0);

        // overflow: writer steps to 17 with the reader idle
        w_bin = 0;
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 17; i++) begin
            w_bin = w_bin + 1;
            cycle(0, to_gray(w_bin), 0, 1);
        end
        for (int i = 0; i < 3; i++) cycle(0, to_gray(w_bin), 0, 1);
        #1;
        chk("ovf_count", 32'(count), 32'd17);
        chk("ovf_err", 32'(gray_err), 32'd1);
        cycle(1, 0, 0, 1);
        #1;
        chk("ovf_rst_count", 32'(count), 32'd0);
        chk("ovf_rst_err", 32'(gray_err), 32'd0);
        w_bin = 0;

        // randomized legal traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                w_bin = 0;
                cycle(1, 0, 1'($urandom_range(0, 1)), 1);
            end else begin
                if (((w_bin - m_rd + PMOD) % PMOD) < 16 && $urandom_range(0, 1) == 1)
                    w_bin = (w_bin + 1) % PMOD;
                cycle(0, to_gray(w_bin), 1'($urandom_range(0, 1)), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
